data_access_unit: RTL and testbench

- Memory-side stage directly downstream of the load/store buffer. Takes one LSB access request (byte, half word or word; read or write) and serialises it onto the byte-wide RAM/IO port.
- Returns the load result or the write completion to the LSB.
- Shares the RAM port with instruction fetch through an external arbiter (memRequest/memGrant).

---
 rtl/data_access_unit.sv | 112 +++++++++++
 tb/tb_data_access_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/data_access_unit.sv
// data_access_unit: serialises one LSB byte/half/word access onto the byte-wide RAM/IO port
module data_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter bit IO_CHECK   = 1'b1
) (
    input  logic                  clockIn,
    input  logic                  resetIn,
    input  logic                  clearIn,
    input  logic [1:0]            accessType,
    input  logic                  readWriteIn,
    input  logic [31:0]           reqAddr,
    input  logic [31:0]           reqData,
    output logic                  dataValid,
    output logic [31:0]           dataOut,
    output logic                  dataWriteSuc,
    output logic                  memRequest,
    input  logic                  memGrant,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memWrite,
    output logic [7:0]            memDout,
    input  logic [7:0]            memDin,
    input  logic                  ioBufferFull
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t                state_q, state_d;
    logic [31:0]           addr_q, addr_d, data_q, data_d, result_q, result_d;
    logic                  rw_q, rw_d, cap_q, cap_d;
    logic [2:0]            n_q, n_d, idx_q, idx_d;
    logic [1:0]            cap_idx_q, cap_idx_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           cur_addr;
    logic                  stall, issue_rd, issue_wr;

    // Next-state, byte sequencing and read-byte capture
    always_comb begin
        cur_addr   = addr_q + {29'd0, idx_q};
        stall      = IO_CHECK && ioBufferFull && (cur_addr[17:16] == 2'b11);
        issue_rd   = (state_q == READ) && memGrant && (idx_q < n_q);
        issue_wr   = (state_q == WRITE) && memGrant && !stall;
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rw_d       = rw_q;
        n_d        = n_q;
        idx_d      = (issue_rd || issue_wr) ? idx_q + 3'd1 : idx_q;
        result_d   = result_q;
        cap_d      = issue_rd;
        cap_idx_d  = idx_q[1:0];
        mem_addr_d = (issue_rd || issue_wr) ? cur_addr[ADDR_WIDTH-1:0] : mem_addr_q;
        case (state_q)
            IDLE: begin
                // a flushed read is simply dropped; a store is already committed and goes ahead
                if (accessType != 2'b00 && !(readWriteIn && clearIn)) begin
                    addr_d   = reqAddr;
                    data_d   = reqData;
                    rw_d     = readWriteIn;
                    n_d      = (accessType == 2'b11) ? 3'd4 : {1'b0, accessType};
                    idx_d    = 3'd0;
                    result_d = readWriteIn ? 32'd0 : result_q;
                    state_d  = readWriteIn ? READ : WRITE;
                end
            end
            READ: begin
                if (cap_q)
                    result_d[8*cap_idx_q +: 8] = memDin;
                state_d = clearIn ? IDLE
                        : (cap_q && {1'b0, cap_idx_q} == n_q - 3'd1) ? RESP : READ;
            end
            WRITE:   state_d = (issue_wr && idx_q == n_q - 3'd1) ? RESP : WRITE;
            default: state_d = IDLE;
        endcase
    end

    // Port and response outputs derived from the current state
    always_comb begin
        memAddr      = mem_addr_d;
        memWrite     = issue_wr;
        memDout      = data_q[8*idx_q[1:0] +: 8];
        memRequest   = state_q != IDLE;
        dataValid    = (state_q == RESP) && rw_q && !clearIn;
        dataWriteSuc = (state_q == RESP) && !rw_q;
        dataOut      = result_q;
    end

    // State registers, cleared asynchronously so the port is released at once
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            rw_q       <= 1'b0;
            n_q        <= '0;
            idx_q      <= '0;
            result_q   <= '0;
            cap_q      <= 1'b0;
            cap_idx_q  <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rw_q       <= rw_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            result_q   <= result_d;
            cap_q      <= cap_d;
            cap_idx_q  <= cap_idx_d;
            mem_addr_q <= mem_addr_d;
        end
    end
endmodule

// File: tb/tb_data_access_unit.sv
// tb_data_access_unit: directed cycle-by-cycle checks of the data access unit
module tb_data_access_unit;
    logic        clk = 1'b0;
    logic        rst_n, clr, rw, grant, ibf;
    logic [1:0]  acc;
    logic [31:0] raddr, rdata;
    logic [7:0]  din;
    logic        dv, dws, mreq, mw, dv2, dws2, mreq2, mw2;
    logic [31:0] dout, maddr, dout2, maddr2;
    logic [7:0]  mdout, mdout2;
    logic [7:0]  ram [0:4095];
    int          checks = 0, errors = 0, wr_cnt = 0, dv_cnt = 0, w0, d0;
    logic [31:0] wd;

    always #5 clk = ~clk;

    data_access_unit #(.ADDR_WIDTH(32), .IO_CHECK(1'b1)) dut (
        .clockIn(clk), .resetIn(rst_n), .clearIn(clr), .accessType(acc), .readWriteIn(rw),
        .reqAddr(raddr), .reqData(rdata), .dataValid(dv), .dataOut(dout), .dataWriteSuc(dws),
        .memRequest(mreq), .memGrant(grant), .memAddr(maddr), .memWrite(mw), .memDout(mdout),
        .memDin(din), .ioBufferFull(ibf));

    data_access_unit #(.ADDR_WIDTH(32), .IO_CHECK(1'b0)) dut2 (
        .clockIn(clk), .resetIn(rst_n), .clearIn(clr), .accessType(acc), .readWriteIn(rw),
        .reqAddr(raddr), .reqData(rdata), .dataValid(dv2), .dataOut(dout2), .dataWriteSuc(dws2),
        .memRequest(mreq2), .memGrant(grant), .memAddr(maddr2), .memWrite(mw2), .memDout(mdout2),
        .memDin(din), .ioBufferFull(ibf));

    // RAM returns the addressed byte one cycle after the address
    always_ff @(posedge clk) din <= ram[maddr[11:0]];

    // Mid-cycle event counters and request-while-busy protocol watch
    always @(negedge clk) begin
        if (mw) wr_cnt++;
        if (dv) dv_cnt++;
        if (acc != 2'b00 && mreq) begin
            errors++;
            $error("FAIL protocol: accessType=%0d while memRequest=1, required idle", acc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] t, input logic r, input logic [31:0] a, input logic [31:0] d);
        acc = t; rw = r; raddr = a; rdata = d;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        ram[12'hFFE] = 8'hA1; ram[12'hFFF] = 8'hB2; ram[12'h000] = 8'hC3; ram[12'h001] = 8'hD4;
        rst_n = 1'b0; clr = 1'b0; grant = 1'b1; ibf = 1'b0; req(2'b00, 1'b0, 32'd0, 32'd0);
        #2;
        chk("rst memRequest", mreq, 0);
        chk("rst memWrite", mw, 0);
        chk("rst dataValid", dv, 0);
        chk("rst dataWriteSuc", dws, 0);
        chk("rst dataOut", dout, 0);
        chk("rst memAddr", maddr, 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

        // word read at 0x100
        nxt(); req(2'b11, 1'b1, 32'h100, 32'd0);
        #1 chk("t1 idle memRequest", mreq, 0);
        for (int k = 0; k < 4; k++) begin
            nxt(); acc = 2'b00;
            #1 chk($sformatf("t1 memAddr c%0d", k + 1), maddr, 32'h100 + k);
            chk($sformatf("t1 memRequest c%0d", k + 1), mreq, 1);
            chk($sformatf("t1 dataValid c%0d", k + 1), dv, 0);
        end
        nxt(); #1 chk("t1 dataValid c5", dv, 0);
        chk("t1 memAddr hold c5", maddr, 32'h103);
        nxt(); #1 chk("t1 dataValid c6", dv, 1);
        chk("t1 dataOut", dout, 32'h44332211);
        nxt(); #1 chk("t1 dataValid c7", dv, 0);
        chk("t1 memRequest c7", mreq, 0);

        // byte write of 0xDEADBEEF to 0x207
        w0 = wr_cnt;
        nxt(); req(2'b01, 1'b0, 32'h207, 32'hDEADBEEF);
        nxt(); acc = 2'b00;
        #1 chk("t2 memWrite c1", mw, 1);
        chk("t2 memAddr c1", maddr, 32'h207);
        chk("t2 memDout c1", mdout, 8'hEF);
        chk("t2 dataWriteSuc c1", dws, 0);
        nxt(); #1 chk("t2 memWrite c2", mw, 0);
        chk("t2 dataWriteSuc c2", dws, 1);
        nxt(); #1 chk("t2 dataWriteSuc c3", dws, 0);
        chk("t2 write count", wr_cnt - w0, 1);

        // half-word IO write under ioBufferFull, IO_CHECK=1 (dut) and IO_CHECK=0 (dut2)
        nxt(); req(2'b10, 1'b0, 32'h30000, 32'h0000ABCD);
        nxt(); acc = 2'b00; ibf = 1'b1;
        #1 chk("t3 stall memWrite c1", mw, 0);
        chk("t3 nochk memWrite c1", mw2, 1);
        chk("t3 nochk memAddr c1", maddr2, 32'h30000);
        chk("t3 nochk memDout c1", mdout2, 8'hCD);
        nxt(); #1 chk("t3 stall memWrite c2", mw, 0);
        chk("t3 nochk memWrite c2", mw2, 1);
        chk("t3 nochk memAddr c2", maddr2, 32'h30001);
        chk("t3 nochk memDout c2", mdout2, 8'hAB);
        nxt(); #1 chk("t3 stall memWrite c3", mw, 0);
        chk("t3 nochk dataWriteSuc c3", dws2, 1);
        nxt(); ibf = 1'b0;
        #1 chk("t3 memWrite c4", mw, 1);
        chk("t3 memAddr c4", maddr, 32'h30000);
        chk("t3 memDout c4", mdout, 8'hCD);
        nxt(); #1 chk("t3 memWrite c5", mw, 1);
        chk("t3 memAddr c5", maddr, 32'h30001);
        chk("t3 memDout c5", mdout, 8'hAB);
        chk("t3 dataWriteSuc c5", dws, 0);
        nxt(); #1 chk("t3 dataWriteSuc c6", dws, 1);
        nxt(); #1 chk("t3 memRequest c7", mreq, 0);

        // wrapping word read with a grant gap in cycle 2
        nxt(); req(2'b11, 1'b1, 32'hFFFFFFFE, 32'd0);
        nxt(); acc = 2'b00;
        #1 chk("t4 memAddr c1", maddr, 32'hFFFFFFFE);
        nxt(); grant = 1'b0;
        #1 chk("t4 memAddr hold c2", maddr, 32'hFFFFFFFE);
        nxt(); grant = 1'b1;
        #1 chk("t4 memAddr c3", maddr, 32'hFFFFFFFF);
        nxt(); #1 chk("t4 memAddr c4", maddr, 32'h0);
        nxt(); #1 chk("t4 memAddr c5", maddr, 32'h1);
        nxt(); #1 chk("t4 dataValid c6", dv, 0);
        nxt(); #1 chk("t4 dataValid c7", dv, 1);
        chk("t4 dataOut", dout, 32'hD4C3B2A1);
        nxt();

        // word read aborted by clearIn in cycle 3
        d0 = dv_cnt;
        nxt(); req(2'b11, 1'b1, 32'h100, 32'd0);
        nxt(); acc = 2'b00;
        nxt();
        nxt(); clr = 1'b1;
        #1 chk("t5 dataValid c3", dv, 0);
        nxt(); clr = 1'b0;
        #1 chk("t5 memRequest c4", mreq, 0);
        repeat (4) nxt();
        #1 chk("t5 no dataValid", dv_cnt - d0, 0);
        chk("t5 memRequest c8", mreq, 0);

        // word write continues through clearIn in cycle 2
        w0 = wr_cnt; wd = 32'h12345678;
        nxt(); req(2'b11, 1'b0, 32'h300, wd);
        for (int k = 0; k < 4; k++) begin
            nxt(); acc = 2'b00; clr = (k == 1);
            #1 chk($sformatf("t6 memWrite c%0d", k + 1), mw, 1);
            chk($sformatf("t6 memAddr c%0d", k + 1), maddr, 32'h300 + k);
            chk($sformatf("t6 memDout c%0d", k + 1), mdout, wd[8*k +: 8]);
        end
        nxt(); clr = 1'b0;
        #1 chk("t6 dataWriteSuc c5", dws, 1);
        nxt(); #1 chk("t6 write count", wr_cnt - w0, 4);
        chk("t6 memRequest c6", mreq, 0);

        // clearIn with a new request: read dropped, write accepted
        nxt(); req(2'b01, 1'b1, 32'h100, 32'd0); clr = 1'b1;
        nxt(); acc = 2'b00; clr = 1'b0;
        #1 chk("t7 read dropped memRequest", mreq, 0);
        nxt(); req(2'b01, 1'b0, 32'h10, 32'h55); clr = 1'b1;
        nxt(); acc = 2'b00; clr = 1'b0;
        #1 chk("t7 write kept memWrite", mw, 1);
        chk("t7 write kept memDout", mdout, 8'h55);
        nxt(); #1 chk("t7 dataWriteSuc", dws, 1);
        nxt();

        // reset in the middle of a word write, then a fresh byte read
        nxt(); req(2'b11, 1'b0, 32'h400, 32'hCAFEF00D);
        nxt(); acc = 2'b00;
        nxt(); #1 chk("t8 memWrite before reset", mw, 1);
        #1 rst_n = 1'b0;
        #1 chk("t8 reset memWrite", mw, 0);
        chk("t8 reset memRequest", mreq, 0);
        chk("t8 reset dataOut", dout, 0);
        chk("t8 reset memAddr", maddr, 0);
        nxt(); nxt(); rst_n = 1'b1;
        nxt(); req(2'b01, 1'b1, 32'h100, 32'd0);
        #1 chk("t8 idle after reset", mreq, 0);
        nxt(); acc = 2'b00;
        #1 chk("t8 memAddr c1", maddr, 32'h100);
        nxt(); #1 chk("t8 dataValid c2", dv, 0);
        nxt(); #1 chk("t8 dataValid c3", dv, 1);
        chk("t8 dataOut", dout, 32'h00000011);
        nxt(); #1 chk("t8 dataValid c4", dv, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
